// File: rtl/mem_data_hs.sv
// mem_data_hs: word-addressed data RAM behind a valid/ready handshake.
// A request is taken in IDLE. Writes commit on the accept edge, and only the
// enabled byte lanes change. Reads capture the addressed word on the same edge.
// After p_WAIT_CYCLES wait cycles the response is presented in RESP and held
// there until the consumer takes it.
// Ports:
//   i_clk, i_rst_n       clock and asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_we, i_req_addr, i_req_be, i_req_wdata
//                        request channel
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err
//                        response channel (err = address out of range)
//   o_busy               high whenever the FSM is not in IDLE
module mem_data_hs #(
   parameter int p_WORD_LEN    = 16,
   parameter int p_ADDR_LEN    = 10,
   parameter int p_DEPTH       = 1024,
   parameter int p_WAIT_CYCLES = 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_req_valid,
   output logic                    o_req_ready,
   input  logic                    i_req_we,
   input  logic [p_ADDR_LEN-1:0]   i_req_addr,
   input  logic [p_WORD_LEN/8-1:0] i_req_be,
   input  logic [p_WORD_LEN-1:0]   i_req_wdata,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [p_WORD_LEN-1:0]   o_rsp_rdata,
   output logic                    o_rsp_err,
   output logic                    o_busy
);

   localparam int c_LANES = p_WORD_LEN / 8;
   localparam int c_IDX_W = (p_DEPTH > 1) ? $clog2(p_DEPTH) : 1;
   // The depth is one bit wider than the address so that p_DEPTH = 2**p_ADDR_LEN fits.
   localparam logic [p_ADDR_LEN:0] c_DEPTH = (p_ADDR_LEN + 1)'(p_DEPTH);
   localparam logic [3:0] c_WAIT_LOAD = (p_WAIT_CYCLES > 0) ? 4'(p_WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  state_r, state_nx_s;
   logic [3:0]              cnt_r, cnt_nx_s;
   logic                    accept_s;
   logic                    in_range_s;
   logic                    wr_en_s;
   logic [c_IDX_W-1:0]      idx_s;
   logic [p_WORD_LEN-1:0]   rdata_nx_s;
   logic [p_WORD_LEN-1:0]   rdata_r;
   logic                    err_r;
   logic                    rsp_valid_r;
   logic                    req_ready_r;
   logic                    busy_r;

   // The array is zero at time 0 only; reset never clears it.
   logic [p_WORD_LEN-1:0]   mem_r [0:p_DEPTH-1] = '{default: {p_WORD_LEN{1'b0}}};

   // Range check on the full address; the index is only used when it is in range.
   always_comb begin
      in_range_s = ({1'b0, i_req_addr} < c_DEPTH);
      idx_s      = i_req_addr[c_IDX_W-1:0];
      wr_en_s    = accept_s & i_req_we & in_range_s;
      if (!i_req_we && in_range_s) begin
         rdata_nx_s = mem_r[idx_s];
      end else begin
         rdata_nx_s = {p_WORD_LEN{1'b0}};
      end
   end

   // FSM next state and wait counter.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      accept_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (i_req_valid) begin
               accept_s = 1'b1;
               if (p_WAIT_CYCLES > 0) begin
                  state_nx_s = S_WAIT;
                  cnt_nx_s   = c_WAIT_LOAD;
               end else begin
                  state_nx_s = S_RESP;
               end
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_nx_s = S_RESP;
            end else begin
               cnt_nx_s = cnt_r - 4'd1;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               state_nx_s = S_IDLE;
            end else begin
               state_nx_s = S_RESP;
            end
         end
         default: begin
            state_nx_s = S_IDLE;
            cnt_nx_s   = 4'd0;
         end
      endcase
   end

   // State, counter and registered outputs. The outputs are derived from the next state,
   // so each one matches the state it describes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= S_IDLE;
         cnt_r       <= 4'd0;
         rsp_valid_r <= 1'b0;
         req_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         rdata_r     <= {p_WORD_LEN{1'b0}};
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         cnt_r       <= cnt_nx_s;
         rsp_valid_r <= (state_nx_s == S_RESP);
         req_ready_r <= (state_nx_s == S_IDLE);
         busy_r      <= (state_nx_s != S_IDLE);
         if (accept_s) begin
            rdata_r <= rdata_nx_s;
            err_r   <= ~in_range_s;
         end else begin
            rdata_r <= rdata_r;
            err_r   <= err_r;
         end
      end
   end

   // Byte-lane merged write. It commits on the accept edge and is kept across reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_s) begin
         for (int k = 0; k < c_LANES; k++) begin
            if (i_req_be[k]) begin
               mem_r[idx_s][8*k +: 8] <= i_req_wdata[8*k +: 8];
            end
         end
      end
   end

   assign o_req_ready = req_ready_r;
   assign o_rsp_valid = rsp_valid_r;
   assign o_rsp_rdata = rdata_r;
   assign o_rsp_err   = err_r;
   assign o_busy      = busy_r;

endmodule

// File: doc/mem_data_hs.md
Name: mem_data_hs

Overview:
- Parametrised successor to the single-cycle data memory: word-addressed data RAM behind a valid/ready request/response handshake.
- Adds configurable wait states, per-byte write enables, out-of-range error reporting and response backpressure.
- Sits between the pipelined core's MEM stage (or a future bus arbiter) and on-chip data storage. Lets the core tolerate slower memories without changing its control logic.

Parameters:
- p_WORD_LEN, 16, bits per word; must be a multiple of 8.
- p_ADDR_LEN, 10, width of the address bus.
- p_DEPTH, 1024, number of implemented words; 1 <= p_DEPTH <= 2**p_ADDR_LEN.
- p_WAIT_CYCLES, 1, extra cycles between request accept and response valid; 0 to 15.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  block can accept a request this cycle.
- i_req_we  input  1  1 = write, 0 = read.
- i_req_addr  input  p_ADDR_LEN  word address.
- i_req_be  input  p_WORD_LEN/8  byte-lane write enables; bit k covers bits [8k+7:8k]; ignored on reads.
- i_req_wdata  input  p_WORD_LEN  write data.
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  consumer accepts the response.
- o_rsp_rdata  output  p_WORD_LEN  read data.
- o_rsp_err  output  1  request address was >= p_DEPTH.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, i_rst_n = 0):
  - FSM goes to IDLE and the wait counter clears.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_busy = 0, o_req_ready = 1 once reset is released.
  - Memory array is NOT cleared by reset. It initialises to all zeros at time 0 only.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - o_req_ready = 1.
  - On i_req_valid at a rising edge the request is accepted.
  - Next state is WAIT with the counter loaded to p_WAIT_CYCLES-1 if p_WAIT_CYCLES > 0; otherwise next state is RESP.
- WAIT:
  - o_req_ready = 0.
  - Counter decrements every cycle; when it reaches 0 the next state is RESP.
- RESP:
  - o_rsp_valid = 1; o_rsp_rdata and o_rsp_err are held stable.
  - On i_rsp_ready the next state is IDLE.
  - If i_rsp_ready stays low, the block stays in RESP indefinitely.
  - o_req_ready = 0 in RESP; there is no back-to-back overlap.
- Latency: request accepted at edge T gives o_rsp_valid high starting the cycle after edge T+p_WAIT_CYCLES.
  - p_WAIT_CYCLES = 0: response is valid in the cycle immediately after accept.
- Throughput: at most one transaction per p_WAIT_CYCLES+2 cycles.
- Commit and capture timing:
  - A write commits on the accept edge.
  - A read captures the array word on the accept edge.
  - Later array changes cannot alter a pending response.
- Writes:
  - Only lanes with i_req_be[k] = 1 are updated; the other lanes keep their old value.
  - be = 0 is legal: no change, normal response.
  - A write response has o_rsp_rdata = 0.
- Out of range (i_req_addr >= p_DEPTH):
  - Writes are suppressed and reads return 0.
  - o_rsp_err = 1 in the response; timing is unchanged.
  - o_rsp_err = 0 for in-range requests.
- Addresses are never truncated or wrapped. Range is checked on the full p_ADDR_LEN bits.
- Inputs other than i_req_valid are sampled only on the accept edge; changes at other times are ignored.
- i_req_valid while busy is not accepted. The requester must hold the request until o_req_ready.
- Reset mid-operation (WAIT or RESP):
  - The pending response is discarded and the FSM returns to IDLE.
  - A write already committed on its accept edge stays in memory.
- After a response is accepted, o_rsp_rdata and o_rsp_err keep their last values while o_rsp_valid = 0.
- Formal: for any constant address, the stored word equals the last committed byte-merged write, and a read response to it returns that value.

Test Plan:
- Defaults, write addr 5 data 0xBEEF be=11, then read addr 5 with i_rsp_ready = 1 -> each response has o_rsp_valid high in the 2nd cycle after accept; read returns 0xBEEF, err = 0; write response rdata = 0.
- Byte lanes: write 0x1234 be=11, then 0xAB00 be=10 to addr 7, then read addr 7 -> 0xAB34; a further be=00 write leaves 0xAB34.
- Backpressure: read response held with i_rsp_ready = 0 for 5 cycles while the array is rewritten externally via a second bench write attempt -> o_req_ready = 0 throughout, rdata stable, second request accepted only after i_rsp_ready = 1.
- Range, p_DEPTH = 1000: write 0x5555 to addr 1000 then read addr 1000 -> err = 1, rdata = 0; read addr 999 -> err = 0.
- p_WAIT_CYCLES = 0 and = 3: measure accept-to-valid -> exactly 1 and 4 cycles respectively; o_busy high from accept until the response handshake.
- Reset asserted in WAIT after a write of 0x0F0F to addr 2 -> o_rsp_valid never rises, state returns to IDLE asynchronously; a later read of addr 2 returns 0x0F0F.
